riscv_dm_dbus_slave_0p11: RTL and testbench

Core-clock-side dbus target for the RISC-V External Debug Support v0.11 JTAG DTM. It accepts dbus requests ({addr, data, op}) that arrive through the DTM's clock-domain-crossing request channel and executes them as single accesses on a simple debug-register bus. It returns one {data, resp} response per request on the response channel. It is the stage that consumes `dtm_req_*` and produces `dtm_resp_*` on the Debug Module side.

---
 rtl/riscv_dm_0p11_pkg.sv | 27 ++
 rtl/riscv_dm_dbus_slave_0p11.sv | 169 ++++++++++++++++
 tb/tb_riscv_dm_dbus_slave_0p11.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dm_0p11_pkg.sv
// Shared types for the RISC-V debug v0.11 dbus: op/resp codes, slave FSM states, default widths.
package riscv_dm_0p11_pkg;

  localparam int unsigned DBUS_DATA_BITS_DEF = 34;
  localparam int unsigned DBUS_ADDR_BITS_DEF = 5;
  localparam int unsigned DBUS_OP_BITS_DEF   = 2;

  typedef enum logic [1:0] {
    DBUS_OP_NOP   = 2'd0,
    DBUS_OP_READ  = 2'd1,
    DBUS_OP_WRITE = 2'd2,
    DBUS_OP_RSVD  = 2'd3
  } dbus_op_e;

  typedef enum logic [1:0] {
    DBUS_RESP_SUCCESS = 2'd0,
    DBUS_RESP_FAILED  = 2'd2
  } dbus_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } dbus_state_e;

endpackage

// File: rtl/riscv_dm_dbus_slave_0p11.sv
// Core-side dbus target: executes one DTM dbus request at a time as a single debug-register access.
// Optional access timeout in WAIT is enabled by defining RISCV_DBUS_TIMEOUT_EN.
module riscv_dm_dbus_slave_0p11
  import riscv_dm_0p11_pkg::*;
#(
  parameter int unsigned DEBUG_DATA_BITS = DBUS_DATA_BITS_DEF,
  parameter int unsigned DEBUG_ADDR_BITS = DBUS_ADDR_BITS_DEF,
  parameter int unsigned DEBUG_OP_BITS   = DBUS_OP_BITS_DEF,
  parameter int unsigned DBUS_REQ_BITS   = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS,
  parameter int unsigned DBUS_RESP_BITS  = DEBUG_OP_BITS + DEBUG_DATA_BITS,
  parameter int unsigned NUM_REGS        = 24,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dtm_req_valid,
  output logic                       dtm_req_ready,
  input  logic [DBUS_REQ_BITS-1:0]   dtm_req_bits,
  output logic                       dtm_resp_valid,
  input  logic                       dtm_resp_ready,
  output logic [DBUS_RESP_BITS-1:0]  dtm_resp_bits,
  output logic                       reg_req,
  output logic                       reg_we,
  output logic [DEBUG_ADDR_BITS-1:0] reg_addr,
  output logic [DEBUG_DATA_BITS-1:0] reg_wdata,
  input  logic                       reg_gnt,
  input  logic                       reg_rvalid,
  input  logic [DEBUG_DATA_BITS-1:0] reg_rdata,
  input  logic                       reg_err
);

  if (DEBUG_OP_BITS != 2) begin : g_bad_op_bits
    $error("riscv_dm_dbus_slave_0p11: DEBUG_OP_BITS must be 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("riscv_dm_dbus_slave_0p11: TIMEOUT_CYCLES must be at least 1");
  end

  dbus_state_e                state_q, state_d;
  dbus_resp_e                 resp_q, resp_d;
  logic [DEBUG_DATA_BITS-1:0] hold_q, hold_d;
  logic [DEBUG_DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DEBUG_ADDR_BITS-1:0] addr_q, addr_d;
  logic                       we_q, we_d;

  dbus_op_e                   req_op;
  logic [DEBUG_DATA_BITS-1:0] req_data;
  logic [DEBUG_ADDR_BITS-1:0] req_addr;
  logic                       req_addr_ok;

`ifdef RISCV_DBUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign req_op      = dbus_op_e'(dtm_req_bits[1:0]);
  assign req_data    = dtm_req_bits[DEBUG_OP_BITS +: DEBUG_DATA_BITS];
  assign req_addr    = dtm_req_bits[DEBUG_OP_BITS + DEBUG_DATA_BITS +: DEBUG_ADDR_BITS];
  assign req_addr_ok = 32'(req_addr) < NUM_REGS;

  // Handshake outputs come straight from the state register, never from inputs.
  assign dtm_req_ready  = (state_q == ST_IDLE);
  assign dtm_resp_valid = (state_q == ST_RESP);
  assign reg_req        = (state_q == ST_ACCESS);
  assign reg_we         = we_q;
  assign reg_addr       = addr_q;
  assign reg_wdata      = wdata_q;
  // The held data register always carries the data returned with the response.
  assign dtm_resp_bits  = {hold_q, DEBUG_OP_BITS'(resp_q)};

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    hold_d  = hold_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    we_d    = we_q;
`ifdef RISCV_DBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (dtm_req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_data;
          we_d    = (req_op == DBUS_OP_WRITE);
          unique case (req_op)
            DBUS_OP_NOP: begin
              state_d = ST_RESP;
              resp_d  = DBUS_RESP_SUCCESS;
            end
            DBUS_OP_READ, DBUS_OP_WRITE: begin
              if (req_addr_ok) begin
                state_d = ST_ACCESS;
              end else begin
                state_d = ST_RESP;
                resp_d  = DBUS_RESP_FAILED;
              end
            end
            default: begin
              state_d = ST_RESP;
              resp_d  = DBUS_RESP_FAILED;
            end
          endcase
        end
      end
      ST_ACCESS: begin
        if (reg_gnt) begin
          state_d = ST_WAIT;
`ifdef RISCV_DBUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (reg_rvalid) begin
          state_d = ST_RESP;
          resp_d  = reg_err ? DBUS_RESP_FAILED : DBUS_RESP_SUCCESS;
          if (we_q) begin
            hold_d = wdata_q;
          end else if (!reg_err) begin
            hold_d = reg_rdata;
          end
        end
`ifdef RISCV_DBUS_TIMEOUT_EN
        else begin
          // Expiry is judged on the incremented count so RESP follows the last counted cycle.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d = ST_RESP;
            resp_d  = DBUS_RESP_FAILED;
          end
        end
`endif
      end
      ST_RESP: begin
        if (dtm_resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      resp_q  <= DBUS_RESP_SUCCESS;
      hold_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
`ifdef RISCV_DBUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      hold_q  <= hold_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
`ifdef RISCV_DBUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_riscv_dm_dbus_slave_0p11.sv
// Directed bench for riscv_dm_dbus_slave_0p11 with hand-computed expectations.
module tb_riscv_dm_dbus_slave_0p11;

  localparam int unsigned DW = 34;
  localparam int unsigned AW = 5;
  localparam int unsigned OW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dtm_req_valid;
  logic          dtm_req_ready;
  logic [40:0]   dtm_req_bits;
  logic          dtm_resp_valid;
  logic          dtm_resp_ready;
  logic [35:0]   dtm_resp_bits;
  logic          reg_req;
  logic          reg_we;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          reg_gnt;
  logic          reg_rvalid;
  logic [DW-1:0] reg_rdata;
  logic          reg_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned gnt_cnt = 0;
  logic        req_seen = 1'b0;
  logic [DW-1:0] held;

  riscv_dm_dbus_slave_0p11 #(
    .DEBUG_DATA_BITS(DW),
    .DEBUG_ADDR_BITS(AW),
    .DEBUG_OP_BITS  (OW),
    .NUM_REGS       (24),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dtm_req_valid (dtm_req_valid),
    .dtm_req_ready (dtm_req_ready),
    .dtm_req_bits  (dtm_req_bits),
    .dtm_resp_valid(dtm_resp_valid),
    .dtm_resp_ready(dtm_resp_ready),
    .dtm_resp_bits (dtm_resp_bits),
    .reg_req       (reg_req),
    .reg_we        (reg_we),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_gnt       (reg_gnt),
    .reg_rvalid    (reg_rvalid),
    .reg_rdata     (reg_rdata),
    .reg_err       (reg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_req && reg_gnt) gnt_cnt++;
    if (reg_req) req_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [1:0] op, input logic [DW-1:0] d);
    chk("req_ready_idle", dtm_req_ready, 1);
    dtm_req_valid = 1'b1;
    dtm_req_bits  = {a, d, op};
    tick();
    dtm_req_valid = 1'b0;
  endtask

  task automatic bus_cycle(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd, input logic err);
    chk("reg_req_access", reg_req, 1);
    chk("reg_we", reg_we, we);
    chk("reg_addr", reg_addr, a);
    chk("reg_wdata", reg_wdata, wd);
    chk("req_ready_busy", dtm_req_ready, 0);
    reg_gnt = 1'b1;
    tick();
    reg_gnt = 1'b0;
    chk("reg_req_wait", reg_req, 0);
    chk("resp_valid_wait", dtm_resp_valid, 0);
    reg_rvalid = 1'b1;
    reg_rdata  = rd;
    reg_err    = err;
    tick();
    reg_rvalid = 1'b0;
    reg_err    = 1'b0;
  endtask

  task automatic take_resp(input string tag, input logic [DW-1:0] d, input logic [1:0] r);
    chk({tag, "_valid"}, dtm_resp_valid, 1);
    chk({tag, "_bits"}, dtm_resp_bits, {d, r});
    dtm_resp_ready = 1'b1;
    tick();
    dtm_resp_ready = 1'b0;
    chk({tag, "_done"}, dtm_resp_valid, 0);
    chk({tag, "_ready"}, dtm_req_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    dtm_req_valid = 1'b0;
    dtm_req_bits = '0;
    dtm_resp_ready = 1'b0;
    reg_gnt = 1'b0;
    reg_rvalid = 1'b0;
    reg_rdata = '0;
    reg_err = 1'b0;
    held = '0;
    #12;
    chk("rst_req_ready", dtm_req_ready, 1);
    chk("rst_resp_valid", dtm_resp_valid, 0);
    chk("rst_resp_bits", dtm_resp_bits, 0);
    chk("rst_reg_req", reg_req, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    rst_n = 1'b1;
    tick();

    // Write then read back address 3
    issue(5'd3, 2'd2, 34'h2_DEAD_BEEF);
    bus_cycle(1'b1, 5'd3, 34'h2_DEAD_BEEF, 34'h0_0000_1234, 1'b0);
    held = 34'h2_DEAD_BEEF;
    take_resp("write3", held, 2'd0);
    issue(5'd3, 2'd1, 34'h0);
    bus_cycle(1'b0, 5'd3, 34'h0, 34'h2_DEAD_BEEF, 1'b0);
    take_resp("read3", 34'h2_DEAD_BEEF, 2'd0);
    chk("grant_count", gnt_cnt, 2);

    // NOP: response one cycle after accept, no bus activity
    req_seen = 1'b0;
    issue(5'd0, 2'd0, 34'h155);
    take_resp("nop", held, 2'd0);
    chk("nop_no_req", req_seen, 0);

    // Out-of-range address and reserved op
    issue(5'd30, 2'd1, 34'h0);
    take_resp("bad_addr", held, 2'd2);
    issue(5'd2, 2'd3, 34'h3_FFFF_0000);
    take_resp("rsvd_op", held, 2'd2);
    chk("err_no_req", req_seen, 0);

    // Read error keeps held data
    issue(5'd5, 2'd1, 34'h0);
    bus_cycle(1'b0, 5'd5, 34'h0, 34'h0_1111_2222, 1'b1);
    take_resp("read_err", held, 2'd2);

    // reg_rvalid in the grant cycle is ignored
    issue(5'd5, 2'd1, 34'h0);
    chk("g_reg_req", reg_req, 1);
    reg_gnt = 1'b1;
    reg_rvalid = 1'b1;
    reg_err = 1'b1;
    reg_rdata = 34'h3_3333_3333;
    tick();
    reg_gnt = 1'b0;
    reg_rvalid = 1'b0;
    reg_err = 1'b0;
    chk("g_rvalid_ignored", dtm_resp_valid, 0);
    reg_rvalid = 1'b1;
    reg_rdata = 34'h1_0000_0001;
    tick();
    reg_rvalid = 1'b0;
    held = 34'h1_0000_0001;
    take_resp("read_after_g", held, 2'd0);

    // Backpressure on grant and on response
    issue(5'd7, 2'd2, 34'h3_0F0F_0F0F);
    for (int i = 0; i < 10; i++) begin
      chk("bp_reg_req", reg_req, 1);
      chk("bp_reg_fields", {reg_we, reg_addr, reg_wdata}, {1'b1, 5'd7, 34'h3_0F0F_0F0F});
      chk("bp_req_ready", dtm_req_ready, 0);
      tick();
    end
    bus_cycle(1'b1, 5'd7, 34'h3_0F0F_0F0F, 34'h0, 1'b0);
    held = 34'h3_0F0F_0F0F;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", dtm_resp_valid, 1);
      chk("bp_resp_bits", dtm_resp_bits, {held, 2'd0});
      chk("bp_req_ready2", dtm_req_ready, 0);
      chk("bp_reg_req2", reg_req, 0);
      tick();
    end
    take_resp("bp", held, 2'd0);

    // Withheld reg_rvalid
    issue(5'd1, 2'd1, 34'h0);
    chk("to_reg_req", reg_req, 1);
    reg_gnt = 1'b1;
    tick();
    reg_gnt = 1'b0;
`ifdef RISCV_DBUS_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      chk("to_pending", dtm_resp_valid, 0);
      tick();
    end
    chk("to_expired", dtm_resp_valid, 1);
    reg_rvalid = 1'b1;
    reg_rdata = 34'h0_00AB_CDEF;
    tick();
    take_resp("timeout", held, 2'd2);
    tick();
    reg_rvalid = 1'b0;
    issue(5'd0, 2'd0, 34'h0);
    take_resp("after_late", held, 2'd0);
`else
    for (int i = 0; i < 20; i++) begin
      chk("wait_forever", dtm_resp_valid, 0);
      tick();
    end
    reg_rvalid = 1'b1;
    reg_rdata = 34'h0_00AB_CDEF;
    tick();
    reg_rvalid = 1'b0;
    held = 34'h0_00AB_CDEF;
    take_resp("long_wait", held, 2'd0);
`endif

    // Asynchronous reset in WAIT
    issue(5'd2, 2'd1, 34'h0);
    reg_gnt = 1'b1;
    tick();
    reg_gnt = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_reg_req", reg_req, 0);
    chk("arst_resp_valid", dtm_resp_valid, 0);
    chk("arst_resp_bits", dtm_resp_bits, 0);
    chk("arst_req_ready", dtm_req_ready, 1);
    chk("arst_reg_addr", reg_addr, 0);
    #2;
    rst_n = 1'b1;
    held = '0;
    tick();
    chk("post_rst_no_resp", dtm_resp_valid, 0);
    tick();
    chk("post_rst_no_resp2", dtm_resp_valid, 0);
    issue(5'd4, 2'd1, 34'h0);
    bus_cycle(1'b0, 5'd4, 34'h0, 34'h2_5555_AAAA, 1'b0);
    held = 34'h2_5555_AAAA;
    take_resp("post_rst_read", held, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
